// File: rtl/pow_5_rr_scheduler.sv
// pow_5_rr_scheduler: round-robin issue of N requesters onto one fixed-latency pow_5 pipe; `define POW5_SCHED_CHECK_EN adds sticky chk_err
module pow_5_rr_scheduler #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int RES_W = 5*W,
  parameter int LAT   = 4
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_en,
  input  logic [N-1:0]     req_vld,
  input  logic [N*W-1:0]   req_n,
  output logic [N-1:0]     req_rdy,
  output logic             pipe_n_vld,
  output logic [W-1:0]     pipe_n,
  input  logic             pipe_res_vld,
  input  logic [RES_W-1:0] pipe_res,
  output logic [N-1:0]     rsp_vld,
  output logic [RES_W-1:0] rsp_res,
  output logic             busy
`ifdef POW5_SCHED_CHECK_EN
  ,
  output logic             chk_err
`endif
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  logic [IW-1:0] ptr, win, cand;
  logic any, grant;
  logic [LAT-1:0] tag_vld;
  logic [IW-1:0] tag_id [LAT];
  // Round-robin search starting just after the last winner, wrapping at N
  always_comb begin
    win = '0;
    cand = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req_vld[cand]) begin
        win = cand;
        any = 1'b1;
      end
    end
  end
  assign grant      = rst_n & issue_en & any;
  assign req_rdy    = grant ? N'(1) << win : '0;
  assign pipe_n_vld = grant;
  assign pipe_n     = grant ? req_n[win*W +: W] : '0;
  assign busy       = |tag_vld;
  // Pointer remembers the last winner so it gets lowest priority next time
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= IW'(N-1);
    else if (grant) ptr <= win;
  // Tag valids track ops in flight; reset drops them so no responses follow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tag_vld <= '0;
    else begin
      tag_vld[0] <= grant;
      for (int k = 1; k < LAT; k++) tag_vld[k] <= tag_vld[k-1];
    end
  // Tag IDs are qualified by the valids, so they need no reset
  always_ff @(posedge clk) begin
    tag_id[0] <= win;
    for (int k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
  end
  // Steer the result that lines up with the oldest tag back to its owner
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_vld <= '0;
      rsp_res <= '0;
    end else begin
      rsp_vld <= tag_vld[LAT-1] ? N'(1) << tag_id[LAT-1] : '0;
      if (tag_vld[LAT-1]) rsp_res <= pipe_res;
    end
`ifdef POW5_SCHED_CHECK_EN
  // Sticky flag: datapath valid disagreed with the expected tag valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chk_err <= 1'b0;
    else if (pipe_res_vld != tag_vld[LAT-1]) chk_err <= 1'b1;
`else
  logic unused_pipe_res_vld;
  assign unused_pipe_res_vld = pipe_res_vld;
`endif
endmodule
